uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the counter/transmitter top level and consumes its o_tx line.
- Recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) and presents each byte with a one-cycle valid strobe.
- Flags framing errors.
- Serves as the loopback checker for the counter's transmitted values on the bench and on the board.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit (1 MHz clk, ~9600 baud); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), derived; offset from the start edge to the mid-bit sample point.

Ports:
- clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_enable  input  1  receiver enable; low forces IDLE
- i_rx  input  1  serial line, idle high, asynchronous to clk
- o_data  output  8  last correctly received byte
- o_valid  output  1  one-cycle strobe; o_data updated this cycle
- o_frame_err  output  1  one-cycle strobe; stop bit sampled low
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0, state=IDLE, synchronizer flops=1.
- i_reset is asynchronous assert with synchronous-style deassert use; it aborts any frame immediately and emits no strobe.
- Synchronizer: i_rx passes through 2 flops. A third flop holds the previous synced value for edge detection.
- Start trigger is a falling edge only (prev=1, cur=0), not a low level. A held-low line (break) never retriggers.
- States and transitions:
  - IDLE: cnt=0, bit_idx=0. On falling edge with i_enable=1, go to START.
  - START: cnt counts 0..HALF_BIT-1. At HALF_BIT-1, sample the line. If low, go to DATA with cnt=0. If high (glitch), return to IDLE with no strobe.
  - DATA: cnt counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift the sample into the shift register at position bit_idx (LSB first) and reset cnt. After bit_idx=7, go to STOP.
  - STOP: cnt counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, sample the line:
    - High: on the next cycle o_data=shift register and o_valid=1 for exactly one cycle.
    - Low: o_frame_err=1 for one cycle and o_data is unchanged.
    - Either way, return to IDLE.
- Sample points fall at synced edge + HALF_BIT + k*CLKS_PER_BIT, for k=0 (start), 1..8 (data), 9 (stop).
- o_valid rises between HALF_BIT+9*CLKS_PER_BIT+2 and +4 clocks after the i_rx pin falling edge; the range covers synchronizer phase.
- A falling edge arriving in the same cycle the STOP state returns to IDLE is detected. Back-to-back frames with a one-bit stop and no idle gap must be received.
- i_enable low in any state: next cycle go to IDLE, discard the partial byte, emit no strobe. Edges are ignored while i_enable is low.
- o_valid and o_frame_err are never high in the same cycle. o_data holds its value between strobes.
- Counter width is $clog2(CLKS_PER_BIT); bit_idx is 3 bits. No wrap beyond the terminal counts above.
- o_busy is combinational from state (state != IDLE).

Test Plan (CLKS_PER_BIT=16 for simulation):
- Reset, then drive 0xA5 frame (bits 1,0,1,0,0,1,0,1, stop=1) at 16 clk/bit → one o_valid pulse, o_data=8'hA5, o_frame_err never high, o_busy low afterwards.
- Frames 0x00, 0xFF, 0x3C back-to-back with no idle gap → three o_valid pulses in order with matching o_data, each between 8+144+2 and 8+144+4 clocks after its start edge.
- 0x5A frame with stop bit driven 0, line then held low for 50 bits → one o_frame_err pulse, o_data keeps its prior value, no retrigger during the low hold, next valid frame 0x11 → o_data=8'h11.
- 3-clock low glitch on idle line → START then IDLE, o_busy high for ≤ 9 cycles, no strobes.
- Assert i_reset at bit 4 of a 0xC3 frame → all outputs 0 within the same cycle (asynchronous). Following frame 0x7E received correctly.
- Drop i_enable at bit 2 of a frame, raise it after the frame ends → no strobes. Next frame 0x81 → o_valid, o_data=8'h81.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronised line, falling-edge start detect,
// mid-bit sampling, one-cycle valid / framing-error strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;

    logic          w_fall;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_valid_nxt;
    logic          w_ferr_nxt;

    assign w_fall      = r_prev & ~r_sync2;
    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != S_IDLE);

    // Line synchroniser plus previous-value flop for edge detection
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Frame state machine: next-state, counters, shift register and strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_idx_nxt   = 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = CNT_ZERO;
                    w_idx_nxt = 3'd0;
                    if (w_fall) begin
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF_END) begin
                        w_cnt_nxt = CNT_ZERO;
                        // A start bit that is already high again was a glitch
                        if (!r_sync2) begin
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_BIT_END) begin
                        w_cnt_nxt              = CNT_ZERO;
                        w_shift_nxt[r_bit_idx] = r_sync2;
                        if (r_bit_idx == 3'd7) begin
                            w_idx_nxt   = 3'd0;
                            w_state_nxt = S_STOP;
                        end else begin
                            w_idx_nxt   = r_bit_idx + 3'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_BIT_END) begin
                        w_cnt_nxt = CNT_ZERO;
                        if (r_sync2) begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                        end
                        // An edge landing on the exit cycle must not be lost
                        if (w_fall) begin
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_idx_nxt   = 3'd0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= CNT_ZERO;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

endmodule
